cp_fifo_controller: RTL
=======================

// Module: cp_fifo_controller
// PURPOSE
// Sequences the command processor GP FIFO: tracks write/read pointers and RW distance in the ring
// FIFOBase..FIFOEnd, issues 32-byte burst reads to memory, forwards fetched words to the command
// decoder, and raises breakpoint/overflow/underflow events consumed by CPRegisters.
// PARAMETERS
// BURST_BYTES  32  bytes per gather-pipe write and per memory read burst (8 x 32-bit beats)
// ERR_W        16  width of FIFOErrors counter
// PORTS
// clk                input   1   system clock
// reset              input   1   synchronous, active-high reset
// FIFOBase/FIFOEnd   input   32  ring bounds, 32B aligned; FIFOEnd = address of last 32B block
// FIFOHighWatermark  input   32  overflow threshold (bytes)
// FIFOLowWatermark   input   32  underflow threshold (bytes)
// FIFOBreakpoint     input   32  read-pointer breakpoint address
// FIFOAXIBase        input   32  physical base added to FIFO addresses
// FIFONewBase        input   1   pulse: reload pointers from FIFOBase
// EnGPFIFO/EnBP      input   1   read enable / breakpoint enable
// EnFIFOOverflow/EnFIFOUnderflow input 1 watermark event enables
// GPWriteValid       input   1   pulse: CPU completed one 32B write at FIFOWritePointer
// MemReq             output  1   burst read request; held until MemAck
// MemAddr            output  32  FIFOAXIBase + {FIFOReadPointer[31:5],5'b0}
// MemAck             input   1   request accepted
// MemDataValid/MemData/MemDataLast  input 1/32/1  read beats; Last on 8th beat
// CmdValid/CmdData   output  1/32  word to command decoder (no backpressure)
// CmdSpace           input   1   decoder has >= 8 free words
// CmdIdle            input   1   decoder idle
// FIFORWDistance/FIFOWritePointer/FIFOReadPointer  output 32  status to CPRegisters
// IntBP/IntFIFOverflow/IntFIFOUnderflow  output 1  single-cycle event pulses
// StatGPIdle/StatGPReadIdle  output 1  idle status
// FIFOErrors         output  ERR_W  dropped-write counter
// BEHAVIOUR
// - Reset: all pointers/distance/FIFOErrors = 0, MemReq = CmdValid = 0, Int* = 0, state IDLE.
// - Pointer advance: next = (ptr == FIFOEnd) ? FIFOBase : ptr + 32. Size = FIFOEnd-FIFOBase+32.
// - GPWriteValid: if distance == Size -> write dropped, pointer/distance unchanged, error counted;
//   else WritePointer advances, distance += 32 next cycle.
// - FSM IDLE -> REQ when EnGPFIFO & distance >= 32 & CmdSpace & ~bpHalt; MemReq=1 in REQ.
//   REQ -> DATA on MemAck. DATA: each MemDataValid -> CmdValid=1, CmdData=MemData same cycle
//   (combinational pass, 0 added latency). MemDataLast -> IDLE; ReadPointer advances, distance -= 32.
// - Write complete and read complete in same cycle: both pointers advance, distance unchanged.
// - bpHalt: EnBP & ReadPointer == {FIFOBreakpoint[31:5],5'b0} while IDLE -> no new bursts;
//   IntBP pulses once on entry; released when EnBP clears or breakpoint/pointer changes.
// - EnGPFIFO cleared in REQ/DATA: current burst completes normally, then IDLE.
// - FIFONewBase: next cycle both pointers = FIFOBase, distance = 0; if in REQ/DATA, burst finishes
//   but its beats are suppressed (CmdValid=0) and pointer/distance are not updated; wins over
//   simultaneous GPWriteValid (write discarded, not counted).
// - IntFIFOverflow: one pulse on transition distance <= High -> distance > High, gated by enable.
//   IntFIFOUnderflow: one pulse on transition distance >= Low -> distance < Low, gated by enable.
// - StatGPReadIdle = (state==IDLE); StatGPIdle = StatGPReadIdle & distance==0 & CmdIdle.
// - MemAddr stable while MemReq high; Mem* beats outside DATA ignored.
// CONFIGURATION
// CP_FIFO_ERRCNT_EN defined: FIFOErrors increments (saturating at all-ones) per dropped write.
// Not defined: FIFOErrors tied to 0; dropped-write behaviour unchanged.
// TESTING
// 1 Base=0x1000,End=0x10E0, 3 writes -> WP=0x1060, dist=0x60; reads 3 bursts, MemAddr=AXIBase+0x1000.. then dist=0.
// 2 Fill 8 writes (Size=0x100) then 9th -> dist stays 0x100, FIFOErrors=1 (with macro), WP wraps to 0x1000.
// 3 High=0x40: writes to dist 0x60 with EnFIFOOverflow=1 -> one IntFIFOverflow pulse at 0x40->0x60 only.
// 4 EnBP=1, Breakpoint=0x1040, 4 writes -> 2 bursts, IntBP one pulse, MemReq stays 0 until EnBP=0.
// 5 FIFONewBase mid-DATA -> no CmdValid for remaining beats, RP=WP=Base, dist=0, next state IDLE.
// 6 GPWriteValid on same cycle as MemDataLast at dist=0x40 -> dist stays 0x40, both pointers +32.

Source files
------------

// File: rtl/cp_fifo_controller.sv
// GP FIFO sequencer: ring pointers, RW distance, 32-byte burst fetch, breakpoint and watermark events.
// Optional: define CP_FIFO_ERRCNT_EN to count dropped gather-pipe writes in FIFOErrors.
module cp_fifo_controller #(
    parameter int unsigned BURST_BYTES = 32,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      FIFOBase,
    input  logic [31:0]      FIFOEnd,
    input  logic [31:0]      FIFOHighWatermark,
    input  logic [31:0]      FIFOLowWatermark,
    input  logic [31:0]      FIFOBreakpoint,
    input  logic [31:0]      FIFOAXIBase,
    input  logic             FIFONewBase,
    input  logic             EnGPFIFO,
    input  logic             EnBP,
    input  logic             EnFIFOOverflow,
    input  logic             EnFIFOUnderflow,
    input  logic             GPWriteValid,
    output logic             MemReq,
    output logic [31:0]      MemAddr,
    input  logic             MemAck,
    input  logic             MemDataValid,
    input  logic [31:0]      MemData,
    input  logic             MemDataLast,
    output logic             CmdValid,
    output logic [31:0]      CmdData,
    input  logic             CmdSpace,
    input  logic             CmdIdle,
    output logic [31:0]      FIFORWDistance,
    output logic [31:0]      FIFOWritePointer,
    output logic [31:0]      FIFOReadPointer,
    output logic             IntBP,
    output logic             IntFIFOverflow,
    output logic             IntFIFOUnderflow,
    output logic             StatGPIdle,
    output logic             StatGPReadIdle,
    output logic [ERR_W-1:0] FIFOErrors
);

    localparam logic [31:0] BURST      = 32'(BURST_BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(BURST - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    state_t      state;
    logic [31:0] wp;
    logic [31:0] rp;
    logic [31:0] distance;
    logic        discard;
    logic        bp_seen;

    logic [31:0] size;
    logic [31:0] wp_adv;
    logic [31:0] rp_adv;
    logic        full;
    logic        wr_ok;
    logic        beat;
    logic        rd_done;
    logic        bp_match;
    logic        start;
    logic [31:0] dist_next;

    assign size     = FIFOEnd - FIFOBase + BURST;
    assign wp_adv   = (wp == FIFOEnd) ? FIFOBase : wp + BURST;
    assign rp_adv   = (rp == FIFOEnd) ? FIFOBase : rp + BURST;
    assign full     = (distance == size);
    assign wr_ok    = GPWriteValid & ~FIFONewBase & ~full;
    assign beat     = (state == S_DATA) & MemDataValid;
    assign rd_done  = beat & MemDataLast & ~discard & ~FIFONewBase;
    assign bp_match = EnBP & (rp == (FIFOBreakpoint & ALIGN_MASK));
    assign start    = (state == S_IDLE) & EnGPFIFO & (distance >= BURST) & CmdSpace
                      & ~bp_match & ~FIFONewBase;

    // A write and a read retiring together leave the distance unchanged
    always_comb begin
        dist_next = distance;
        if (FIFONewBase) begin
            dist_next = '0;
        end else if (wr_ok && !rd_done) begin
            dist_next = distance + BURST;
        end else if (!wr_ok && rd_done) begin
            dist_next = distance - BURST;
        end
    end

    // Beats stream straight through; a rebased burst drains silently
    assign CmdValid = beat & ~discard & ~FIFONewBase;
    assign CmdData  = MemData;

    assign FIFORWDistance   = distance;
    assign FIFOWritePointer = wp;
    assign FIFOReadPointer  = rp;
    assign StatGPReadIdle   = (state == S_IDLE);
    assign StatGPIdle       = StatGPReadIdle & (distance == 32'd0) & CmdIdle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            wp               <= '0;
            rp               <= '0;
            distance         <= '0;
            discard          <= 1'b0;
            bp_seen          <= 1'b0;
            MemReq           <= 1'b0;
            MemAddr          <= '0;
            IntBP            <= 1'b0;
            IntFIFOverflow   <= 1'b0;
            IntFIFOUnderflow <= 1'b0;
        end else begin
            distance <= dist_next;
            if (FIFONewBase) begin
                wp <= FIFOBase;
                rp <= FIFOBase;
            end else begin
                if (wr_ok) begin
                    wp <= wp_adv;
                end
                if (rd_done) begin
                    rp <= rp_adv;
                end
            end

            IntFIFOverflow   <= EnFIFOOverflow & (distance <= FIFOHighWatermark)
                                & (dist_next > FIFOHighWatermark);
            IntFIFOUnderflow <= EnFIFOUnderflow & (distance >= FIFOLowWatermark)
                                & (dist_next < FIFOLowWatermark);

            // Breakpoint fires once per arrival; clears when the match goes away
            IntBP   <= (state == S_IDLE) & bp_match & ~bp_seen;
            bp_seen <= bp_match & (bp_seen | (state == S_IDLE));

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        MemReq  <= 1'b1;
                        MemAddr <= FIFOAXIBase + (rp & ALIGN_MASK);
                    end
                end
                S_REQ: begin
                    if (FIFONewBase) begin
                        discard <= 1'b1;
                    end
                    if (MemAck) begin
                        state  <= S_DATA;
                        MemReq <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (FIFONewBase) begin
                        discard <= 1'b1;
                    end
                    if (beat && MemDataLast) begin
                        state   <= S_IDLE;
                        discard <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    MemReq <= 1'b0;
                end
            endcase
        end
    end

`ifdef CP_FIFO_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt;
    logic             wr_drop;

    assign wr_drop = GPWriteValid & ~FIFONewBase & full;

    // Saturating count of writes refused because the ring was full
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (wr_drop && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    assign FIFOErrors = err_cnt;
`else
    assign FIFOErrors = '0;
`endif

endmodule
